// File: rtl/dedisp_boxcar_detect.sv
// Per-frame power integrator followed by a WIN_LEN-frame boxcar and a threshold detector.
// Define DEDISP_SAT_EN to make the integrator saturate and report it on sat_flag.
module dedisp_boxcar_detect #(
  parameter int unsigned DIN_WIDTH = 26,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned WIN_LEN   = 8,
  parameter int unsigned HOLDOFF   = 16,
  localparam int unsigned SUM_WIDTH = ACC_WIDTH + $clog2(WIN_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_valid,
  input  logic                 din_sof,
  input  logic                 din_eof,
  input  logic [SUM_WIDTH-1:0] threshold,
  output logic [ACC_WIDTH-1:0] integ_pow,
  output logic                 integ_valid,
  output logic [SUM_WIDTH-1:0] boxcar_sum,
  output logic                 boxcar_valid,
  output logic                 detect,
  output logic                 frame_err,
  output logic                 sat_flag,
  output logic [31:0]          frame_cnt
);

  localparam int unsigned PtrW  = $clog2(WIN_LEN);
  localparam int unsigned FillW = PtrW + 1;
  localparam int unsigned HoldW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [0:0] {StIdle, StInFrame} state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_add, din_ext;
  logic                 frame_done, frame_err_d;
  logic                 frame_pend_q;
  logic [ACC_WIDTH-1:0] integ_pow_q;
  logic                 integ_valid_q, frame_err_q;
  logic [31:0]          frame_cnt_q;

  logic [ACC_WIDTH-1:0] buf_q [WIN_LEN];
  logic [PtrW-1:0]      ptr_q;
  logic [FillW-1:0]     fill_q;
  logic [SUM_WIDTH-1:0] sum_q, sum_new;
  logic [ACC_WIDTH-1:0] oldest;
  logic                 full, win_ready;
  logic [HoldW-1:0]     hold_q;
  logic                 boxcar_valid_q, detect_q, detect_d;

`ifdef DEDISP_SAT_EN
  logic [ACC_WIDTH:0]   add_full;
  logic                 sat_run_q, sat_run_d, sat_flag_q;
`endif

  // Framing and integration.
  always_comb begin
    din_ext = ACC_WIDTH'(din);
`ifdef DEDISP_SAT_EN
    add_full  = {1'b0, acc_q} + {1'b0, din_ext};
    acc_add   = add_full[ACC_WIDTH] ? '1 : add_full[ACC_WIDTH-1:0];
    sat_run_d = sat_run_q;
`else
    acc_add = acc_q + din_ext;
`endif
    state_d     = state_q;
    acc_d       = acc_q;
    frame_done  = 1'b0;
    frame_err_d = 1'b0;
    if (din_valid) begin
      if (din_sof) begin
        // A sof inside an open frame abandons it and starts afresh.
        frame_err_d = (state_q == StInFrame);
        acc_d       = din_ext;
        state_d     = StInFrame;
        frame_done  = din_eof;
`ifdef DEDISP_SAT_EN
        sat_run_d = 1'b0;
`endif
      end else if (state_q == StInFrame) begin
        acc_d      = acc_add;
        frame_done = din_eof;
`ifdef DEDISP_SAT_EN
        sat_run_d = sat_run_q | add_full[ACC_WIDTH];
`endif
      end
    end
    if (frame_done) state_d = StIdle;
  end

  // Boxcar window; slots not yet written count as zero until the window has filled.
  always_comb begin
    full      = (fill_q == FillW'(WIN_LEN));
    win_ready = (fill_q >= FillW'(WIN_LEN - 1));
    oldest    = full ? buf_q[ptr_q] : '0;
    sum_new   = sum_q + SUM_WIDTH'(integ_pow_q) - SUM_WIDTH'(oldest);
    detect_d  = frame_pend_q && win_ready && (sum_new > threshold) && (hold_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      acc_q          <= '0;
      frame_pend_q   <= 1'b0;
      integ_pow_q    <= '0;
      integ_valid_q  <= 1'b0;
      frame_err_q    <= 1'b0;
      frame_cnt_q    <= '0;
      ptr_q          <= '0;
      fill_q         <= '0;
      sum_q          <= '0;
      hold_q         <= '0;
      boxcar_valid_q <= 1'b0;
      detect_q       <= 1'b0;
    end else if (ce) begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      frame_pend_q   <= frame_done;
      integ_valid_q  <= frame_done;
      frame_err_q    <= frame_err_d;
      boxcar_valid_q <= frame_pend_q && win_ready;
      detect_q       <= detect_d;
      if (frame_done) begin
        integ_pow_q <= acc_d;
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
      if (frame_pend_q) begin
        sum_q <= sum_new;
        ptr_q <= ptr_q + PtrW'(1);
        if (!full) fill_q <= fill_q + FillW'(1);
        if (detect_d) begin
          hold_q <= HoldW'(HOLDOFF);
        end else if (hold_q != '0) begin
          hold_q <= hold_q - HoldW'(1);
        end
      end
    end else begin
      // Frozen cycle: state holds, strobes drop.
      integ_valid_q  <= 1'b0;
      frame_err_q    <= 1'b0;
      boxcar_valid_q <= 1'b0;
      detect_q       <= 1'b0;
    end
  end

  // Window storage carries no reset; the fill count masks stale contents.
  always_ff @(posedge clk) begin
    if (!rst && ce && frame_pend_q) buf_q[ptr_q] <= integ_pow_q;
  end

`ifdef DEDISP_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_run_q  <= 1'b0;
      sat_flag_q <= 1'b0;
    end else if (ce) begin
      sat_run_q <= sat_run_d;
      if (frame_done) sat_flag_q <= sat_run_d;
    end
  end
  assign sat_flag = sat_flag_q;
`else
  assign sat_flag = 1'b0;
`endif

  assign integ_pow    = integ_pow_q;
  assign integ_valid  = integ_valid_q;
  assign boxcar_sum   = sum_q;
  assign boxcar_valid = boxcar_valid_q;
  assign detect       = detect_q;
  assign frame_err    = frame_err_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_dedisp_boxcar_detect.sv
// Directed bench for dedisp_boxcar_detect with WIN_LEN=4, HOLDOFF=2, 8-bit integrator.
module tb_dedisp_boxcar_detect;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned WL = 4;
  localparam int unsigned HO = 2;
  localparam int unsigned SW = AW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_sof = 1'b0;
  logic          din_eof = 1'b0;
  logic [SW-1:0] threshold = '0;
  logic [AW-1:0] integ_pow;
  logic          integ_valid;
  logic [SW-1:0] boxcar_sum;
  logic          boxcar_valid;
  logic          detect;
  logic          frame_err;
  logic          sat_flag;
  logic [31:0]   frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int iv_cnt = 0;

  dedisp_boxcar_detect #(
    .DIN_WIDTH(DW),
    .ACC_WIDTH(AW),
    .WIN_LEN  (WL),
    .HOLDOFF  (HO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .din         (din),
    .din_valid   (din_valid),
    .din_sof     (din_sof),
    .din_eof     (din_eof),
    .threshold   (threshold),
    .integ_pow   (integ_pow),
    .integ_valid (integ_valid),
    .boxcar_sum  (boxcar_sum),
    .boxcar_valid(boxcar_valid),
    .detect      (detect),
    .frame_err   (frame_err),
    .sat_flag    (sat_flag),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (integ_valid) iv_cnt <= iv_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Presents one beat at a negedge; returns at the next negedge with its result visible.
  task automatic beat(input logic [DW-1:0] d, input logic s, input logic e);
    din = d;
    din_sof = s;
    din_eof = e;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din_sof = 1'b0;
    din_eof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Frame of beats 1,2,3,4 (power 10).
  task automatic frame4(output logic iv, output logic bv, output logic dt);
    beat(8'd1, 1'b1, 1'b0);
    beat(8'd2, 1'b0, 1'b0);
    beat(8'd3, 1'b0, 1'b0);
    beat(8'd4, 1'b0, 1'b1);
    iv = integ_valid;
    @(negedge clk);
    bv = boxcar_valid;
    dt = detect;
    @(negedge clk);
  endtask

  // Single-beat frame (sof and eof together).
  task automatic frame1(input logic [DW-1:0] d, output logic iv, output logic bv,
                        output logic dt);
    beat(d, 1'b1, 1'b1);
    iv = integ_valid;
    @(negedge clk);
    bv = boxcar_valid;
    dt = detect;
    @(negedge clk);
  endtask

  initial begin
    logic iv, bv, dt;
    int   base;

    repeat (3) @(negedge clk);
    check("rst_integ_pow", integ_pow, 0);
    check("rst_integ_valid", integ_valid, 0);
    check("rst_boxcar_sum", boxcar_sum, 0);
    check("rst_boxcar_valid", boxcar_valid, 0);
    check("rst_detect", detect, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_sat_flag", sat_flag, 0);
    rst = 1'b0;

    // Single frame, then window fill to first full sum.
    threshold = 10'd39;
    beat(8'd1, 1'b1, 1'b0);
    beat(8'd2, 1'b0, 1'b0);
    beat(8'd3, 1'b0, 1'b0);
    check("pre_eof_integ_valid", integ_valid, 0);
    beat(8'd4, 1'b0, 1'b1);
    check("f1_integ_valid", integ_valid, 1);
    check("f1_integ_pow", integ_pow, 10);
    check("f1_frame_cnt", frame_cnt, 1);
    @(negedge clk);
    check("f1_integ_valid_drop", integ_valid, 0);
    check("f1_boxcar_valid", boxcar_valid, 0);
    check("f1_boxcar_sum", boxcar_sum, 10);
    @(negedge clk);
    for (int f = 2; f <= 4; f++) begin
      frame4(iv, bv, dt);
      check($sformatf("fill_iv_f%0d", f), iv, 1);
      check($sformatf("fill_bv_f%0d", f), bv, (f == 4) ? 1 : 0);
    end
    check("thr39_sum", boxcar_sum, 40);
    check("thr39_detect", dt, 1);
    check("thr39_frame_cnt", frame_cnt, 4);

    // Strictly-greater compare: sum equal to threshold does not detect.
    do_reset();
    threshold = 10'd40;
    for (int f = 1; f <= 4; f++) frame4(iv, bv, dt);
    check("thr40_bv", bv, 1);
    check("thr40_sum", boxcar_sum, 40);
    check("thr40_detect", dt, 0);

    // Holdoff of two window updates after each detection.
    do_reset();
    threshold = 10'd0;
    for (int f = 1; f <= 8; f++) begin
      frame1(8'd10, iv, bv, dt);
      check($sformatf("hold_bv_f%0d", f), bv, (f >= 4) ? 1 : 0);
      check($sformatf("hold_det_f%0d", f), dt, (f == 4 || f == 7) ? 1 : 0);
    end
    check("hold_sum", boxcar_sum, 40);

    // Integrator overflow.
    do_reset();
    beat(8'd200, 1'b1, 1'b0);
    beat(8'd100, 1'b0, 1'b1);
`ifdef DEDISP_SAT_EN
    check("sat_integ_pow", integ_pow, 255);
    check("sat_flag", sat_flag, 1);
`else
    check("wrap_integ_pow", integ_pow, 44);
    check("wrap_sat_flag", sat_flag, 0);
`endif
    idle(2);

    // Sof inside an open frame restarts it.
    do_reset();
    beat(8'd5, 1'b1, 1'b0);
    check("ferr_first_sof", frame_err, 0);
    beat(8'd7, 1'b1, 1'b0);
    check("ferr_second_sof", frame_err, 1);
    beat(8'd1, 1'b0, 1'b1);
    check("ferr_drop", frame_err, 0);
    check("ferr_integ_pow", integ_pow, 8);
    check("ferr_frame_cnt", frame_cnt, 1);
    idle(2);

    // Reset mid-frame discards the partial frame.
    base = iv_cnt;
    beat(8'd9, 1'b1, 1'b0);
    beat(8'd9, 1'b0, 1'b0);
    do_reset();
    frame4(iv, bv, dt);
    idle(1);
    check("rstmid_iv_count", iv_cnt - base, 1);
    check("rstmid_integ_pow", integ_pow, 10);
    check("rstmid_frame_cnt", frame_cnt, 1);

    // Clock-enable stall mid-frame, then stall right after eof.
    do_reset();
    base = iv_cnt;
    beat(8'd1, 1'b1, 1'b0);
    beat(8'd2, 1'b0, 1'b0);
    beat(8'd3, 1'b0, 1'b0);
    ce = 1'b0;
    idle(3);
    ce = 1'b1;
    check("ce_no_early_iv", iv_cnt - base, 0);
    beat(8'd4, 1'b0, 1'b1);
    check("ce_integ_valid", integ_valid, 1);
    check("ce_integ_pow", integ_pow, 10);
    check("ce_frame_cnt", frame_cnt, 1);
    ce = 1'b0;
    @(negedge clk);
    check("ce_strobe_cleared", integ_valid, 0);
    check("ce_sum_frozen", boxcar_sum, 0);
    ce = 1'b1;
    @(negedge clk);
    check("ce_sum_resumed", boxcar_sum, 10);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dedisp_boxcar_detect.md
DEDISP_BOXCAR_DETECT -- requirements
Module: dedisp_boxcar_detect

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 26: width of the dedispersed power sample; DIN_WIDTH <= ACC_WIDTH.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: width of the per-frame integrator.
REQ-003 SHALL have parameter WIN_LEN, default 8: boxcar length in frames; power of 2, >= 2.
REQ-004 SHALL have parameter HOLDOFF, default 16: frames during which detect is suppressed after a detection; 0 disables holdoff.
REQ-005 SHALL derive localparam SUM_WIDTH = ACC_WIDTH + log2(WIN_LEN).
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk  input  1  rising-edge clock for all logic.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 ce  input  1  clock enable; state updates only when ce=1.
REQ-010 din  input  DIN_WIDTH  unsigned dedispersed power sample.
REQ-011 din_valid  input  1  din qualifier.
REQ-012 din_sof / din_eof  input  1 each  first/last beat of frame; valid only with din_valid.
REQ-013 threshold  input  SUM_WIDTH  unsigned detection threshold, sampled every compare.
REQ-014 integ_pow  output  ACC_WIDTH  last completed frame power.
REQ-015 integ_valid  output  1  one-cycle strobe, integ_pow updated.
REQ-016 boxcar_sum  output  SUM_WIDTH  sum of last WIN_LEN frame powers.
REQ-017 boxcar_valid  output  1  one-cycle strobe, boxcar_sum updated with full window.
REQ-018 detect  output  1  one-cycle strobe coincident with boxcar_valid.
REQ-019 frame_err  output  1  one-cycle strobe: din_sof received inside an open frame.
REQ-020 sat_flag  output  1  sticky: integrator saturated in last completed frame.
REQ-021 frame_cnt  output  32  completed frames, wraps 2^32-1 -> 0.

Function
REQ-022 Framing FSM SHALL have states IDLE and IN_FRAME; beats in IDLE without din_sof SHALL be ignored.
REQ-023 Beat with din_sof SHALL load acc <= din (zero-extended) and enter IN_FRAME; in IN_FRAME a sof SHALL also pulse frame_err and restart the frame.
REQ-024 Valid beat in IN_FRAME without sof SHALL add din to acc.
REQ-025 Beat with din_eof (including sof+eof same beat) SHALL register integ_pow <= final sum, pulse integ_valid next cycle, increment frame_cnt, return to IDLE; eof in IDLE without sof ignored.
REQ-026 Boxcar SHALL be a WIN_LEN-entry circular buffer; per completed frame: sum <= sum + new - oldest, write new, advance pointer (wrap WIN_LEN-1 -> 0).
REQ-027 While fill count < WIN_LEN, oldest SHALL be treated as 0 (buffer needs no reset clear) and boxcar_valid/detect SHALL stay 0.
REQ-028 boxcar_sum/boxcar_valid SHALL update one cycle after integ_valid (2 cycles after eof beat).
REQ-029 detect SHALL assert with boxcar_valid when new sum > threshold (strict) and holdoff counter = 0; on detect, counter loads HOLDOFF and decrements per boxcar update.
REQ-030 ce=0 SHALL freeze all state; strobes SHALL be 0 in any cycle following a ce=0 cycle.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 rst SHALL have priority over ce and clear FSM to IDLE, acc, pointer, fill count, sum, holdoff, frame_cnt and all outputs to 0.
REQ-033 rst mid-frame SHALL discard the partial frame; no integ_valid SHALL result from it.

Configuration
REQ-034 Macro DEDISP_SAT_EN defined: acc SHALL saturate at 2^ACC_WIDTH-1 and sat_flag SHALL report saturation per completed frame.
REQ-035 DEDISP_SAT_EN undefined: acc SHALL wrap modulo 2^ACC_WIDTH; sat_flag SHALL be constant 0.

Verification
REQ-036 WIN_LEN=4: frame din=1,2,3,4 with sof/eof -> integ_pow=10, integ_valid 1 cycle after eof, frame_cnt=1.
REQ-037 Four such frames, threshold=39 -> boxcar_valid first on frame 4 only, boxcar_sum=40, detect=1; threshold=40 -> detect=0.
REQ-038 HOLDOFF=2, threshold=0, 8 frames of power 10 -> detect on frames 4 and 7 only.
REQ-039 ACC_WIDTH=8, frame din=200,100: DEDISP_SAT_EN -> integ_pow=255, sat_flag=1; undefined -> integ_pow=44, sat_flag=0.
REQ-040 sof,5,sof,7,eof(1) -> frame_err pulse on second sof, integ_pow=8.
REQ-041 rst asserted after 2 beats of a frame, then clean frame 1,2,3,4 -> single integ_valid, integ_pow=10, frame_cnt=1; ce low 3 cycles mid-frame -> same result, delayed 3 cycles.
